// File: rtl/seg_display_ctrl_pkg.sv
// Shared segment type and glyph constants for the seven-segment display path.
// Segments are active-low with bit order {g,f,e,d,c,b,a}.
package seg_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_BLANK = 7'b1111111;
    localparam seg_t SEG_DASH  = 7'b0111111;

    localparam seg_t SEG_0 = 7'b1000000;
    localparam seg_t SEG_1 = 7'b1111001;
    localparam seg_t SEG_2 = 7'b0100100;
    localparam seg_t SEG_3 = 7'b0110000;
    localparam seg_t SEG_4 = 7'b0011001;
    localparam seg_t SEG_5 = 7'b0010010;
    localparam seg_t SEG_6 = 7'b0000010;
    localparam seg_t SEG_7 = 7'b1111000;
    localparam seg_t SEG_8 = 7'b0000000;
    localparam seg_t SEG_9 = 7'b0010000;
    localparam seg_t SEG_A = 7'b0001000;
    localparam seg_t SEG_B = 7'b0000011;
    localparam seg_t SEG_C = 7'b1000110;
    localparam seg_t SEG_D = 7'b0100001;
    localparam seg_t SEG_E = 7'b0000110;
    localparam seg_t SEG_F = 7'b0001110;

endpackage

// File: rtl/seg_display_ctrl_glyph.sv
// Combinational nibble-to-glyph decoder; codes 10-15 render as a dash
// unless hex glyphs are enabled.
module seg_glyph
    import seg_pkg::*;
(
    input  logic [3:0] i_nib,
    input  logic       i_hex,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_DASH;
        case (i_nib)
            4'd0:  o_seg = SEG_0;
            4'd1:  o_seg = SEG_1;
            4'd2:  o_seg = SEG_2;
            4'd3:  o_seg = SEG_3;
            4'd4:  o_seg = SEG_4;
            4'd5:  o_seg = SEG_5;
            4'd6:  o_seg = SEG_6;
            4'd7:  o_seg = SEG_7;
            4'd8:  o_seg = SEG_8;
            4'd9:  o_seg = SEG_9;
            4'd10: o_seg = i_hex ? SEG_A : SEG_DASH;
            4'd11: o_seg = i_hex ? SEG_B : SEG_DASH;
            4'd12: o_seg = i_hex ? SEG_C : SEG_DASH;
            4'd13: o_seg = i_hex ? SEG_D : SEG_DASH;
            4'd14: o_seg = i_hex ? SEG_E : SEG_DASH;
            4'd15: o_seg = i_hex ? SEG_F : SEG_DASH;
            default: o_seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg_display_ctrl.sv
// Seven-segment controller: bank capture, glyph decode with blink and
// leading-zero blanking, plus a ghost-guarded multiplexed scan bus.
module seg_display_ctrl
    import seg_pkg::*;
#(
    parameter  int DIGITS    = 4,
    parameter  int SOURCES   = 2,
    parameter  int SCAN_DIV  = 50000,
    parameter  int BLINK_DIV = 25000000,
    localparam int SEL_W     = (SOURCES > 1) ? $clog2(SOURCES) : 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [SOURCES*DIGITS*4-1:0] src_data,
    input  logic [SEL_W-1:0]            src_sel,
    input  logic                        freeze,
    input  logic                        hex_mode,
    input  logic                        blank_lz,
    input  logic [DIGITS-1:0]           blink_mask,
    output logic [DIGITS*7-1:0]         seg_static,
    output logic [6:0]                  seg_mux,
    output logic [DIGITS-1:0]           dig_en_n
);

    localparam int DW     = DIGITS * 4;
    localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int SCNT_W = $clog2(SCAN_DIV);
    localparam int BCNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [DW-1:0]       r_cap;
    logic [DW-1:0]       w_bank;
    logic                w_sel_ok;
    logic [BCNT_W-1:0]   r_blink_cnt;
    logic                r_blink_ph;
    logic [6:0]          w_glyph [DIGITS];
    logic [DIGITS-1:0]   w_lz;
    logic [DIGITS*7-1:0] w_seg_next;
    logic [DIGITS*7-1:0] r_seg_static;
    logic [SCNT_W-1:0]   r_scan_cnt;
    logic [IDX_W-1:0]    r_scan_idx;
    logic [6:0]          w_mux_seg;
    logic [DIGITS-1:0]   w_en_n;
    logic [6:0]          r_seg_mux;
    logic [DIGITS-1:0]   r_dig_en_n;

    // Out-of-range selects leave w_sel_ok low so the capture simply holds.
    always_comb begin
        w_bank   = '0;
        w_sel_ok = 1'b0;
        for (int s = 0; s < SOURCES; s++) begin
            if (int'(src_sel) == s) begin
                w_bank   = src_data[s*DW +: DW];
                w_sel_ok = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cap <= '0;
        end else if (!freeze && w_sel_ok) begin
            r_cap <= w_bank;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_blink_cnt <= '0;
            r_blink_ph  <= 1'b0;
        end else if (r_blink_cnt == BCNT_W'(BLINK_DIV - 1)) begin
            r_blink_cnt <= '0;
            r_blink_ph  <= ~r_blink_ph;
        end else begin
            r_blink_cnt <= r_blink_cnt + BCNT_W'(1);
        end
    end

    for (genvar gd = 0; gd < DIGITS; gd++) begin : g_glyph
        seg_glyph u_glyph (
            .i_nib (r_cap[gd*4 +: 4]),
            .i_hex (hex_mode),
            .o_seg (w_glyph[gd])
        );
    end

    // w_lz[d] is set while digit d and every higher digit are zero.
    always_comb begin
        w_lz = '0;
        w_lz[DIGITS-1] = (r_cap[(DIGITS-1)*4 +: 4] == 4'd0);
        for (int d = DIGITS - 2; d >= 0; d--) begin
            w_lz[d] = w_lz[d+1] && (r_cap[d*4 +: 4] == 4'd0);
        end
    end

    always_comb begin
        w_seg_next = '0;
        for (int d = 0; d < DIGITS; d++) begin
            if (blink_mask[d] && r_blink_ph) begin
                w_seg_next[d*7 +: 7] = SEG_BLANK;
            end else if (blank_lz && (d != 0) && w_lz[d]) begin
                w_seg_next[d*7 +: 7] = SEG_BLANK;
            end else begin
                w_seg_next[d*7 +: 7] = w_glyph[d];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg_static <= {DIGITS{SEG_BLANK}};
        end else begin
            r_seg_static <= w_seg_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scan_cnt <= '0;
            r_scan_idx <= '0;
        end else if (r_scan_cnt == SCNT_W'(SCAN_DIV - 1)) begin
            r_scan_cnt <= '0;
            r_scan_idx <= (r_scan_idx == IDX_W'(DIGITS - 1)) ? '0 : r_scan_idx + IDX_W'(1);
        end else begin
            r_scan_cnt <= r_scan_cnt + SCNT_W'(1);
        end
    end

    always_comb begin
        w_mux_seg = SEG_BLANK;
        w_en_n    = '1;
        for (int d = 0; d < DIGITS; d++) begin
            if (int'(r_scan_idx) == d) begin
                w_mux_seg = r_seg_static[d*7 +: 7];
                w_en_n[d] = 1'b0;
            end
        end
    end

    // First cycle of each slot blanks everything so the previous digit cannot ghost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg_mux  <= SEG_BLANK;
            r_dig_en_n <= '1;
        end else if (r_scan_cnt == '0) begin
            r_seg_mux  <= SEG_BLANK;
            r_dig_en_n <= '1;
        end else begin
            r_seg_mux  <= w_mux_seg;
            r_dig_en_n <= w_en_n;
        end
    end

    assign seg_static = r_seg_static;
    assign seg_mux    = r_seg_mux;
    assign dig_en_n   = r_dig_en_n;

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Directed bench for seg_display_ctrl: capture/freeze, decode modes,
// leading-zero blanking, blink phase and scan sequencing around reset.
module tb_seg_display_ctrl;

    localparam int DIGITS    = 4;
    localparam int SOURCES   = 3;
    localparam int SCAN_DIV  = 3;
    localparam int BLINK_DIV = 4;

    localparam logic [6:0] GB = 7'b1111111;
    localparam logic [6:0] GD = 7'b0111111;
    localparam logic [6:0] G0 = 7'b1000000;
    localparam logic [6:0] G1 = 7'b1111001;
    localparam logic [6:0] G2 = 7'b0100100;
    localparam logic [6:0] G3 = 7'b0110000;
    localparam logic [6:0] G4 = 7'b0011001;
    localparam logic [6:0] G5 = 7'b0010010;
    localparam logic [6:0] G7 = 7'b1111000;
    localparam logic [6:0] G8 = 7'b0000000;
    localparam logic [6:0] G9 = 7'b0010000;
    localparam logic [6:0] GA = 7'b0001000;
    localparam logic [6:0] GF = 7'b0001110;

    logic                        clk = 1'b0;
    logic                        rst_n;
    logic [SOURCES*DIGITS*4-1:0] src_data;
    logic [1:0]                  src_sel;
    logic                        freeze;
    logic                        hex_mode;
    logic                        blank_lz;
    logic [DIGITS-1:0]           blink_mask;
    logic [DIGITS*7-1:0]         seg_static;
    logic [6:0]                  seg_mux;
    logic [DIGITS-1:0]           dig_en_n;

    int total = 0;
    int bad   = 0;

    logic [3:0] en_tab  [17] = '{4'b1111, 4'b1110, 4'b1110, 4'b1111, 4'b1101, 4'b1101,
                                 4'b1111, 4'b1011, 4'b1011, 4'b1111, 4'b0111, 4'b0111,
                                 4'b1111, 4'b1110, 4'b1110, 4'b1111, 4'b1101};
    logic [6:0] mux_tab [17] = '{GB, G0, G4, GB, G3, GB, GB, G2, G2, GB, G1, G1,
                                 GB, G4, G4, GB, GB};

    seg_display_ctrl #(
        .DIGITS    (DIGITS),
        .SOURCES   (SOURCES),
        .SCAN_DIV  (SCAN_DIV),
        .BLINK_DIV (BLINK_DIV)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .src_data   (src_data),
        .src_sel    (src_sel),
        .freeze     (freeze),
        .hex_mode   (hex_mode),
        .blank_lz   (blank_lz),
        .blink_mask (blink_mask),
        .seg_static (seg_static),
        .seg_mux    (seg_mux),
        .dig_en_n   (dig_en_n)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [27:0] obs, input logic [27:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [27:0] exp_s;
        logic        blink_off;

        rst_n      = 1'b0;
        src_data   = 48'({$urandom(), $urandom()});
        src_sel    = 2'($urandom());
        freeze     = 1'($urandom());
        hex_mode   = 1'($urandom());
        blank_lz   = 1'($urandom());
        blink_mask = 4'($urandom());
        repeat (3) tick();
        chk("reset_static", 28'(seg_static), {4{GB}});
        chk("reset_mux", 28'(seg_mux), 28'(GB));
        chk("reset_en", 28'(dig_en_n), 28'(4'b1111));

        src_data   = {16'h0987, 16'h0A5F, 16'h1234};
        src_sel    = 2'd0;
        freeze     = 1'b0;
        hex_mode   = 1'b1;
        blank_lz   = 1'b0;
        blink_mask = 4'b0000;
        rst_n      = 1'b1;
        tick();
        chk("release_cycle1", 28'(seg_static), {4{G0}});
        tick();
        chk("release_bank0", 28'(seg_static), {G1, G2, G3, G4});

        src_sel = 2'd1;
        tick();
        chk("sel1_cycle1", 28'(seg_static), {G1, G2, G3, G4});
        tick();
        chk("sel1_hex", 28'(seg_static), {G0, GA, G5, GF});

        freeze  = 1'b1;
        src_sel = 2'd0;
        repeat (3) tick();
        chk("freeze_hold", 28'(seg_static), {G0, GA, G5, GF});

        hex_mode = 1'b0;
        tick();
        chk("decimal_dash", 28'(seg_static), {G0, GD, G5, GD});

        freeze  = 1'b0;
        src_sel = 2'd3;
        repeat (2) tick();
        chk("sel_out_of_range", 28'(seg_static), {G0, GD, G5, GD});

        src_sel = 2'd2;
        repeat (2) tick();
        chk("bank2_decimal", 28'(seg_static), {G0, G9, G8, G7});
        blank_lz = 1'b1;
        tick();
        chk("lz_one_cycle", 28'(seg_static), {GB, G9, G8, G7});

        src_data = {16'h0007, 16'h0A5F, 16'h1234};
        repeat (2) tick();
        chk("lz_0007", 28'(seg_static), {GB, GB, GB, G7});
        src_data = {16'h0000, 16'h0A5F, 16'h1234};
        repeat (2) tick();
        chk("lz_0000", 28'(seg_static), {GB, GB, GB, G0});
        src_data = {16'h0100, 16'h0A5F, 16'h1234};
        repeat (2) tick();
        chk("lz_0100", 28'(seg_static), {GB, G1, G0, G0});

        rst_n = 1'b0;
        #1;
        chk("async_rst_static", 28'(seg_static), {4{GB}});
        chk("async_rst_en", 28'(dig_en_n), 28'(4'b1111));
        src_sel    = 2'd0;
        blank_lz   = 1'b0;
        hex_mode   = 1'b1;
        blink_mask = 4'b0010;
        tick();
        rst_n = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            tick();
            blink_off = (k >= 5 && k <= 8) || (k >= 13 && k <= 16);
            exp_s = {G1, G2, (blink_off ? GB : G3), G4};
            if (k == 1) exp_s = {4{G0}};
            chk($sformatf("blink_static_k%0d", k), 28'(seg_static), exp_s);
            chk($sformatf("scan_en_k%0d", k), 28'(dig_en_n), 28'(en_tab[k-1]));
            chk($sformatf("scan_mux_k%0d", k), 28'(seg_mux), 28'(mux_tab[k-1]));
        end

        rst_n = 1'b0;
        #1;
        chk("midslot_rst_en", 28'(dig_en_n), 28'(4'b1111));
        chk("midslot_rst_mux", 28'(seg_mux), 28'(GB));
        tick();
        rst_n = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk($sformatf("restart_en_k%0d", k), 28'(dig_en_n), 28'(en_tab[k-1]));
            chk($sformatf("restart_mux_k%0d", k), 28'(seg_mux), 28'(mux_tab[k-1]));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
